// File: rtl/regfile_mp_sb_if.sv
// Register file bus: decoder/controller side (master) drives write, link-write,
// scoreboard-set and read-address signals; the register file (slave) returns
// read data, per-port pending flags, the stall interlock and the link value.
//   regWriteEn/Rdest/writeData     general write port
//   RaWriteEn/RaWriteData          link (return-address) write port
//   pendSetEn/pendSetAddr          mark register as awaiting multi-cycle writeback
//   rdAddr                         NREAD packed read addresses
//   rdData/rdPending/stall/RaData  combinational read results
interface regfile_mp_sb_if #(
  parameter int REGBITS = 5,
  parameter int WIDTH   = 32,
  parameter int NREAD   = 2
);
  logic                     regWriteEn;
  logic [REGBITS-1:0]       Rdest;
  logic [WIDTH-1:0]         writeData;
  logic                     RaWriteEn;
  logic [WIDTH-1:0]         RaWriteData;
  logic                     pendSetEn;
  logic [REGBITS-1:0]       pendSetAddr;
  logic [NREAD*REGBITS-1:0] rdAddr;
  logic [NREAD*WIDTH-1:0]   rdData;
  logic [NREAD-1:0]         rdPending;
  logic                     stall;
  logic [WIDTH-1:0]         RaData;

  modport master (
    output regWriteEn, Rdest, writeData, RaWriteEn, RaWriteData,
           pendSetEn, pendSetAddr, rdAddr,
    input  rdData, rdPending, stall, RaData
  );

  modport slave (
    input  regWriteEn, Rdest, writeData, RaWriteEn, RaWriteData,
           pendSetEn, pendSetAddr, rdAddr,
    output rdData, rdPending, stall, RaData
  );
endinterface

// File: rtl/regfile_mp_sb.sv
// Multi-port register file with link write port and load scoreboard.
//   clk    global clock, all state on posedge
//   reset  synchronous active-high; clears registers and pending bits
//   bus    regfile_mp_sb_if slave modport (see interface header)
// Register 0 is hardwired to zero. Reads are combinational with optional
// same-cycle forwarding of write data (BYPASS). A pending bit per register
// tracks outstanding multi-cycle writebacks; reading a pending register
// raises rdPending/stall.
module regfile_mp_sb #(
  parameter int REGBITS = 5,
  parameter int WIDTH   = 32,
  parameter int NREAD   = 2,
  parameter int RA_IDX  = 31,
  parameter int BYPASS  = 1
) (
  input logic             clk,
  input logic             reset,
  regfile_mp_sb_if.slave  bus
);

  localparam int unsigned NREGS = 2 ** REGBITS;
  localparam logic [REGBITS-1:0] RA_ADDR = RA_IDX[REGBITS-1:0];

  logic [WIDTH-1:0] regs [NREGS];
  logic [NREGS-1:0] pending;
  logic [NREAD-1:0] pendVec;

  logic genWrite;
  logic raDropped;

  assign genWrite  = bus.regWriteEn && (bus.Rdest != '0);
  assign raDropped = bus.regWriteEn && (bus.Rdest == RA_ADDR);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
      pending <= '0;
    end else begin
      // General write is issued after the link write so it wins on RA_IDX.
      if (bus.RaWriteEn && !raDropped) regs[RA_ADDR] <= bus.RaWriteData;
      if (genWrite) regs[bus.Rdest] <= bus.writeData;
      // Set after clear: a newly issued load outranks an arriving writeback.
      if (genWrite) pending[bus.Rdest] <= 1'b0;
      if (bus.pendSetEn && (bus.pendSetAddr != '0)) pending[bus.pendSetAddr] <= 1'b1;
    end
  end

  function automatic logic [WIDTH-1:0] readReg(input logic [REGBITS-1:0] addr);
    if (addr == '0)
      readReg = '0;
    else if ((BYPASS != 0) && bus.regWriteEn && (bus.Rdest == addr))
      readReg = bus.writeData;
    else if ((BYPASS != 0) && bus.RaWriteEn && (addr == RA_ADDR) && !raDropped)
      readReg = bus.RaWriteData;
    else
      readReg = regs[addr];
  endfunction

  always_comb begin
    logic [REGBITS-1:0] a;
    bus.rdData = '0;
    pendVec    = '0;
    for (int unsigned i = 0; i < NREAD; i++) begin
      a = bus.rdAddr[i*REGBITS +: REGBITS];
      bus.rdData[i*WIDTH +: WIDTH] = readReg(a);
      pendVec[i] = pending[a] && (a != '0) &&
                   !((BYPASS != 0) && bus.regWriteEn && (bus.Rdest == a));
    end
  end

  assign bus.rdPending = pendVec;
  assign bus.stall     = |pendVec;
  assign bus.RaData    = readReg(RA_ADDR);

endmodule

// File: tb/tb_regfile_mp_sb.sv
module tb_regfile_mp_sb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Shared stimulus; the 4-bit/16-bit instance sees truncated copies.
  logic        reset;
  logic        we;
  logic [4:0]  rdS;
  logic [31:0] wdS;
  logic        raWe;
  logic [31:0] raWd;
  logic        pSet;
  logic [4:0]  pAddr;
  logic [4:0]  rdA [4];

  int tests = 0;
  int fails = 0;

  regfile_mp_sb_if #(.REGBITS(5), .WIDTH(32), .NREAD(2)) ifA ();
  regfile_mp_sb_if #(.REGBITS(5), .WIDTH(32), .NREAD(2)) ifB ();
  regfile_mp_sb_if #(.REGBITS(4), .WIDTH(16), .NREAD(4)) ifC ();

  regfile_mp_sb #(.REGBITS(5), .WIDTH(32), .NREAD(2), .RA_IDX(31), .BYPASS(1))
    dutA (.clk(clk), .reset(reset), .bus(ifA));
  regfile_mp_sb #(.REGBITS(5), .WIDTH(32), .NREAD(2), .RA_IDX(31), .BYPASS(0))
    dutB (.clk(clk), .reset(reset), .bus(ifB));
  regfile_mp_sb #(.REGBITS(4), .WIDTH(16), .NREAD(4), .RA_IDX(15), .BYPASS(1))
    dutC (.clk(clk), .reset(reset), .bus(ifC));

  assign ifA.regWriteEn = we;    assign ifB.regWriteEn = we;    assign ifC.regWriteEn = we;
  assign ifA.Rdest = rdS;        assign ifB.Rdest = rdS;        assign ifC.Rdest = rdS[3:0];
  assign ifA.writeData = wdS;    assign ifB.writeData = wdS;    assign ifC.writeData = wdS[15:0];
  assign ifA.RaWriteEn = raWe;   assign ifB.RaWriteEn = raWe;   assign ifC.RaWriteEn = raWe;
  assign ifA.RaWriteData = raWd; assign ifB.RaWriteData = raWd; assign ifC.RaWriteData = raWd[15:0];
  assign ifA.pendSetEn = pSet;   assign ifB.pendSetEn = pSet;   assign ifC.pendSetEn = pSet;
  assign ifA.pendSetAddr = pAddr; assign ifB.pendSetAddr = pAddr; assign ifC.pendSetAddr = pAddr[3:0];
  assign ifA.rdAddr = {rdA[1], rdA[0]};
  assign ifB.rdAddr = {rdA[1], rdA[0]};
  assign ifC.rdAddr = {rdA[3][3:0], rdA[2][3:0], rdA[1][3:0], rdA[0][3:0]};

  // Reference model: architectural register contents and pending sets for
  // the three configurations (0 = bypass, 1 = no bypass, 2 = narrow/4-port).
  int          cfgBits [3] = '{5, 5, 4};
  int          cfgRa   [3] = '{31, 31, 15};
  int          cfgByp  [3] = '{1, 0, 1};
  logic [31:0] cfgWm   [3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_FFFF};
  logic [31:0] mReg [3][32];
  logic [31:0] mPend [3];

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int amask(input int k);
    return (1 << cfgBits[k]) - 1;
  endfunction

  function automatic logic [31:0] expRead(input int k, input int addr);
    int a, d;
    a = addr & amask(k);
    d = int'(rdS) & amask(k);
    if (a == 0) return 32'h0;
    if (cfgByp[k] != 0 && we && d == a) return wdS & cfgWm[k];
    if (cfgByp[k] != 0 && raWe && a == cfgRa[k] && !(we && d == cfgRa[k]))
      return raWd & cfgWm[k];
    return mReg[k][a];
  endfunction

  function automatic logic expPend(input int k, input int addr);
    int a, d;
    a = addr & amask(k);
    d = int'(rdS) & amask(k);
    return mPend[k][a] && a != 0 && !(cfgByp[k] != 0 && we && d == a);
  endfunction

  task automatic modelUpdate();
    for (int k = 0; k < 3; k++) begin
      int d, p;
      d = int'(rdS) & amask(k);
      p = int'(pAddr) & amask(k);
      if (reset) begin
        for (int r = 0; r < 32; r++) mReg[k][r] = 32'h0;
        mPend[k] = 32'h0;
      end else begin
        if (raWe) mReg[k][cfgRa[k]] = raWd & cfgWm[k];
        if (we && d != 0) begin
          mReg[k][d] = wdS & cfgWm[k];
          mPend[k][d] = 1'b0;
        end
        if (pSet && p != 0) mPend[k][p] = 1'b1;
      end
    end
  endtask

  task automatic checkModel();
    logic st;
    st = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checkVal($sformatf("A.rdData%0d", i), ifA.rdData[i*32 +: 32], expRead(0, int'(rdA[i])));
      checkVal($sformatf("A.rdPending%0d", i), 32'(ifA.rdPending[i]), 32'(expPend(0, int'(rdA[i]))));
      st |= expPend(0, int'(rdA[i]));
    end
    checkVal("A.stall", 32'(ifA.stall), 32'(st));
    checkVal("A.RaData", ifA.RaData, expRead(0, 31));
    st = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checkVal($sformatf("B.rdData%0d", i), ifB.rdData[i*32 +: 32], expRead(1, int'(rdA[i])));
      checkVal($sformatf("B.rdPending%0d", i), 32'(ifB.rdPending[i]), 32'(expPend(1, int'(rdA[i]))));
      st |= expPend(1, int'(rdA[i]));
    end
    checkVal("B.stall", 32'(ifB.stall), 32'(st));
    checkVal("B.RaData", ifB.RaData, expRead(1, 31));
    st = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checkVal($sformatf("C.rdData%0d", i), 32'(ifC.rdData[i*16 +: 16]), expRead(2, int'(rdA[i])));
      checkVal($sformatf("C.rdPending%0d", i), 32'(ifC.rdPending[i]), 32'(expPend(2, int'(rdA[i]))));
      st |= expPend(2, int'(rdA[i]));
    end
    checkVal("C.stall", 32'(ifC.stall), 32'(st));
    checkVal("C.RaData", 32'(ifC.RaData), expRead(2, 15));
  endtask

  // Inputs are driven after a negedge; compare, clock once, advance model.
  task automatic tick();
    #1;
    checkModel();
    @(posedge clk);
    modelUpdate();
    @(negedge clk);
  endtask

  task automatic setIdle();
    reset = 1'b0; we = 1'b0; rdS = '0; wdS = '0;
    raWe = 1'b0; raWd = '0; pSet = 1'b0; pAddr = '0;
  endtask

  function automatic logic [4:0] rndAddr();
    logic [4:0] pool [7];
    pool = '{5'd0, 5'd1, 5'd3, 5'd9, 5'd15, 5'd31, 5'd25};
    if ($urandom_range(0, 1) == 0) return pool[$urandom_range(0, 6)];
    return 5'($urandom_range(0, 31));
  endfunction

  initial begin
    setIdle();
    for (int i = 0; i < 4; i++) rdA[i] = '0;
    reset = 1'b1;
    @(posedge clk);
    modelUpdate();
    @(negedge clk);
    reset = 1'b0;

    // Post-reset reads and write to register 0.
    rdA[0] = 5'd0; rdA[1] = 5'd5; rdA[2] = 5'd31; rdA[3] = 5'd15;
    #1;
    checkVal("rst.rd1", ifA.rdData[63:32], 32'h0);
    checkVal("rst.stall", 32'(ifA.stall), 32'h0);
    checkVal("rst.RaData", ifA.RaData, 32'h0);
    tick();
    we = 1'b1; rdS = 5'd0; wdS = 32'hDEAD_BEEF;
    tick();
    setIdle();
    #1;
    checkVal("r0.zero", ifA.rdData[31:0], 32'h0);
    tick();

    // Bypass versus stored-value read.
    rdA[0] = 5'd7;
    we = 1'b1; rdS = 5'd7; wdS = 32'h11;
    #1;
    checkVal("byp.A", ifA.rdData[31:0], 32'h11);
    checkVal("byp.B", ifB.rdData[31:0], 32'h0);
    tick();
    setIdle();
    #1;
    checkVal("byp.Bnext", ifB.rdData[31:0], 32'h11);
    tick();

    // Dual write: same target, then different targets.
    we = 1'b1; rdS = 5'd31; wdS = 32'hAAAA_0000; raWe = 1'b1; raWd = 32'h1234_5678;
    tick();
    setIdle(); rdA[0] = 5'd31;
    #1;
    checkVal("dual.same", ifA.rdData[31:0], 32'hAAAA_0000);
    tick();
    we = 1'b1; rdS = 5'd4; wdS = 32'hAAAA_0000; raWe = 1'b1; raWd = 32'h1234_5678;
    tick();
    setIdle(); rdA[0] = 5'd4; rdA[1] = 5'd31;
    #1;
    checkVal("dual.r4", ifA.rdData[31:0], 32'hAAAA_0000);
    checkVal("dual.r31", ifA.rdData[63:32], 32'h1234_5678);
    tick();

    // Scoreboard stall and same-cycle release.
    pSet = 1'b1; pAddr = 5'd9;
    tick();
    setIdle(); rdA[1] = 5'd9;
    for (int n = 0; n < 3; n++) begin
      #1;
      checkVal("sb.pend1", 32'(ifA.rdPending[1]), 32'h1);
      checkVal("sb.stall", 32'(ifA.stall), 32'h1);
      tick();
    end
    we = 1'b1; rdS = 5'd9; wdS = 32'h0000_CAFE;
    #1;
    checkVal("sb.releaseA", 32'(ifA.stall), 32'h0);
    checkVal("sb.dataA", ifA.rdData[63:32], 32'h0000_CAFE);
    checkVal("sb.holdB", 32'(ifB.stall), 32'h1);
    tick();

    // Set and clear of the same register in one cycle: set wins.
    setIdle();
    we = 1'b1; rdS = 5'd9; wdS = 32'h1; pSet = 1'b1; pAddr = 5'd9;
    tick();
    setIdle();
    #1;
    checkVal("setwin.stall", 32'(ifA.stall), 32'h1);
    checkVal("setwin.data", ifA.rdData[63:32], 32'h1);
    tick();

    // Reset mid-load discards pending and the concurrent write.
    pSet = 1'b1; pAddr = 5'd3;
    tick();
    pAddr = 5'd12;
    tick();
    setIdle();
    reset = 1'b1; we = 1'b1; rdS = 5'd3; wdS = 32'h55;
    tick();
    setIdle(); rdA[0] = 5'd3; rdA[1] = 5'd12;
    #1;
    checkVal("rstmid.stall", 32'(ifA.stall), 32'h0);
    checkVal("rstmid.r3", ifA.rdData[31:0], 32'h0);
    tick();

    // Random traffic against the reference model.
    for (int n = 0; n < 600; n++) begin
      reset = ($urandom_range(0, 79) == 0);
      we    = 1'($urandom_range(0, 1));
      rdS   = rndAddr();
      wdS   = $urandom();
      raWe  = ($urandom_range(0, 3) == 0);
      raWd  = $urandom();
      pSet  = ($urandom_range(0, 2) == 0);
      pAddr = rndAddr();
      for (int i = 0; i < 4; i++)
        rdA[i] = ($urandom_range(0, 3) == 0) ? rdS : rndAddr();
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
